operand_bypass_unit: RTL

- Parametrised successor to the combinational forwarding mux: tracks in-flight register writes across DEPTH post-issue stages in an internal shadow pipeline.
- Forwards the youngest ready result to NRD source ports.
- Generates a load-use stall when the youngest producer's data is not yet available.
- Sits between decode/issue and the register file read outputs; drives the issue-stage operand buses and the pipeline hold signal.

---
 rtl/operand_bypass_unit.sv | 113 +++++++++++
 1 files changed

// File: rtl/operand_bypass_unit.sv
// rtl/operand_bypass_unit.sv - operand forwarding with shadow pipeline and load-use stall
module operand_bypass_unit #(
  parameter int XLEN       = 32,
  parameter int RW         = 5,
  parameter int NRD        = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  input  logic                  issue_we,
  input  logic                  issue_load,
  input  logic [RW-1:0]         issue_dst,
  input  logic [NRD*RW-1:0]     rd_addr,
  input  logic [NRD*XLEN-1:0]   rd_regfile,
  input  logic [DEPTH*XLEN-1:0] stage_data,
  input  logic                  pipe_adv,
  input  logic                  flush,
  output logic [NRD*XLEN-1:0]   rd_data,
  output logic [NRD-1:0]        fwd_hit,
  output logic                  stall,
  output logic [15:0]           stall_cnt
);

  // Shadow pipeline: index 0 is stage 1 (EX), index DEPTH-1 is the last tracked stage.
  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] we_q;
  logic [DEPTH-1:0] ld_q;
  logic [RW-1:0]    dst_q [DEPTH];

  // Per-port resolution scratch.
  logic [NRD-1:0]  port_stall;
  logic [RW-1:0]   addr;
  logic            found;
  logic            ready;
  logic [XLEN-1:0] sel_data;

  // Resolve each source port against the youngest matching in-flight producer.
  always_comb begin
    rd_data    = '0;
    fwd_hit    = '0;
    port_stall = '0;
    addr       = '0;
    found      = 1'b0;
    ready      = 1'b0;
    sel_data   = '0;
    for (int p = 0; p < NRD; p++) begin
      addr     = rd_addr[p*RW +: RW];
      found    = 1'b0;
      ready    = 1'b0;
      sel_data = '0;
      // Walk oldest to youngest so the youngest match overwrites older ones.
      for (int s = DEPTH - 1; s >= 0; s--) begin
        if (v_q[s] && we_q[s] && (dst_q[s] == addr)) begin
          found    = 1'b1;
          ready    = ~ld_q[s] | ((s + 1) >= LOAD_STAGE);
          sel_data = stage_data[s*XLEN +: XLEN];
        end
      end
      if (addr == '0) begin
        rd_data[p*XLEN +: XLEN] = '0;
      end else if (found && ready) begin
        rd_data[p*XLEN +: XLEN] = sel_data;
        fwd_hit[p]              = 1'b1;
      end else begin
        // A not-ready youngest producer masks any older ready copy.
        rd_data[p*XLEN +: XLEN] = rd_regfile[p*XLEN +: XLEN];
        port_stall[p]           = found & ~ready;
      end
    end
  end

  // Hold issue only when a real instruction is waiting on an unavailable operand.
  always_comb begin
    stall = issue_valid & (|port_stall);
  end

  // Advance, flush or hold the shadow pipeline; a stalled issue enters as a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q  <= '0;
      we_q <= '0;
      ld_q <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        dst_q[s] <= '0;
      end
    end else if (flush) begin
      v_q <= '0;
    end else if (pipe_adv) begin
      v_q[0]   <= issue_valid & ~stall;
      we_q[0]  <= issue_we;
      ld_q[0]  <= issue_load;
      dst_q[0] <= issue_dst;
      for (int s = 1; s < DEPTH; s++) begin
        v_q[s]   <= v_q[s-1];
        we_q[s]  <= we_q[s-1];
        ld_q[s]  <= ld_q[s-1];
        dst_q[s] <= dst_q[s-1];
      end
    end
  end

  // Saturating count of cycles lost to operand stalls; a flushed cycle is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && !flush && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule
